// File: rtl/tnaf_digit_sequencer_if.sv
// Handshake bundle between the tau-NAF digit sequencer, the recoder, the point unit and the controller.
// Optional stats outputs exist only when TNAF_STATS_EN is defined.
interface tnaf_digit_sequencer_if #(
    parameter int CNT_W = 9
);
    logic             start;
    logic             digit_valid;
    logic             digit_nz;
    logic             digit_sign;
    logic             digit_last;
    logic             digit_ready;
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic             cmd_ready;
    logic             op_done;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] digit_count;
`ifdef TNAF_STATS_EN
    logic [CNT_W-1:0] stat_add;
    logic [CNT_W-1:0] stat_sub;
`endif

    modport master (
        input  start, digit_valid, digit_nz, digit_sign, digit_last, cmd_ready, op_done,
        output digit_ready, cmd_valid, cmd_op, busy, done, error, digit_count
`ifdef TNAF_STATS_EN
        , stat_add, stat_sub
`endif
    );

    modport slave (
        output start, digit_valid, digit_nz, digit_sign, digit_last, cmd_ready, op_done,
        input  digit_ready, cmd_valid, cmd_op, busy, done, error, digit_count
`ifdef TNAF_STATS_EN
        , stat_add, stat_sub
`endif
    );
endinterface

// File: rtl/tnaf_digit_sequencer.sv
// Buffers tau-NAF digits and walks them right-to-left, issuing ADD/SUB then FROB per digit.
// Define TNAF_STATS_EN to add the stat_add/stat_sub handshake counters.
module tnaf_digit_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 9,
    parameter int MAX_DIGITS = 290
) (
    input logic                    clk,
    input logic                    rst,
    tnaf_digit_sequencer_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

    localparam logic [1:0] OP_FROB = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FETCH      = 3'd1;
    localparam logic [2:0] S_ISSUE_PT   = 3'd2;
    localparam logic [2:0] S_WAIT_PT    = 3'd3;
    localparam logic [2:0] S_ISSUE_FROB = 3'd4;
    localparam logic [2:0] S_WAIT_FROB  = 3'd5;
    localparam logic [2:0] S_FINISH     = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             last_pushed_q, last_pushed_d;
    logic             cur_sign_q, cur_sign_d;
    logic             cur_last_q, cur_last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             error_q, error_d;
    logic             ovf_q, ovf_d;

    // Entry layout {last, sign, nz}
    logic [2:0]       fifo_mem_q [FIFO_DEPTH];

    logic             fifo_empty, fifo_full;
    logic             busy_w, ready_w, push, stray_done;
    logic [2:0]       head;
    logic [CNT_W-1:0] cnt_inc;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign cnt_inc    = cnt_q + CNT_ONE;

    assign busy_w     = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign ready_w    = busy_w && !fifo_full && !last_pushed_q;
    // A start in the same cycle flushes the FIFO, so nothing is written then
    assign push       = bus.digit_valid && ready_w && !bus.start;
    // Unarmed (IDLE) op_done is ignored; once armed it is only legal while waiting
    assign stray_done = (state_q != S_IDLE) && (state_q != S_WAIT_PT) &&
                        (state_q != S_WAIT_FROB);

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        last_pushed_d = last_pushed_q;
        cur_sign_d    = cur_sign_q;
        cur_last_d    = cur_last_q;
        cnt_d         = cnt_q;
        error_d       = error_q;
        ovf_d         = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (bus.digit_last) last_pushed_d = 1'b1;
            if (!bus.digit_nz && bus.digit_sign) error_d = 1'b1;
        end
        if (bus.op_done && stray_done) error_d = 1'b1;

        case (state_q)
            S_IDLE: ;
            S_FETCH: begin
                if (!fifo_empty) begin
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    cnt_d      = cnt_inc;
                    cur_sign_d = head[1];
                    cur_last_d = head[2];
                    if (head[0]) begin
                        state_d = S_ISSUE_PT;
                    end else if (head[2]) begin
                        state_d = S_FINISH;
                    end else if (cnt_inc == CNT_MAX) begin
                        state_d = S_FINISH;
                        ovf_d   = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE_FROB;
                    end
                end
            end
            S_ISSUE_PT:   if (bus.cmd_ready) state_d = S_WAIT_PT;
            S_WAIT_PT: begin
                if (bus.op_done) begin
                    if (cur_last_q) begin
                        state_d = S_FINISH;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = S_FINISH;
                        ovf_d   = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE_FROB;
                    end
                end
            end
            S_ISSUE_FROB: if (bus.cmd_ready) state_d = S_WAIT_FROB;
            S_WAIT_FROB:  if (bus.op_done) state_d = S_FETCH;
            default:      state_d = S_IDLE;
        endcase

        // Start arms from any state and abandons whatever was in flight
        if (bus.start) begin
            state_d       = S_FETCH;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            last_pushed_d = 1'b0;
            cnt_d         = '0;
            error_d       = 1'b0;
            ovf_d         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            last_pushed_q <= 1'b0;
            cnt_q         <= '0;
            error_q       <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            last_pushed_q <= last_pushed_d;
            cnt_q         <= cnt_d;
            error_q       <= error_d;
            ovf_q         <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        cur_sign_q <= cur_sign_d;
        cur_last_q <= cur_last_d;
        if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {bus.digit_last, bus.digit_sign, bus.digit_nz};
    end

    assign bus.digit_ready = ready_w;
    assign bus.busy        = busy_w;
    assign bus.cmd_valid   = (state_q == S_ISSUE_PT) || (state_q == S_ISSUE_FROB);
    assign bus.cmd_op      = (state_q == S_ISSUE_PT) ? (cur_sign_q ? OP_SUB : OP_ADD) : OP_FROB;
    // Overflow terminates through FINISH but must not look like a clean completion
    assign bus.done        = (state_q == S_FINISH) && !ovf_q;
    assign bus.error       = error_q;
    assign bus.digit_count = cnt_q;

`ifdef TNAF_STATS_EN
    logic [CNT_W-1:0] stat_add_q, stat_sub_q;

    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            stat_add_q <= '0;
            stat_sub_q <= '0;
        end else if ((state_q == S_ISSUE_PT) && bus.cmd_ready) begin
            if (cur_sign_q) stat_sub_q <= stat_sub_q + CNT_ONE;
            else            stat_add_q <= stat_add_q + CNT_ONE;
        end
    end

    assign bus.stat_add = stat_add_q;
    assign bus.stat_sub = stat_sub_q;
`endif
endmodule
